// File: rtl/hog_pkg.sv
// Shared HOG pipeline definitions: window-controller FSM states and default geometry.
package hog_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2
    } win_state_t;

    localparam int DEF_IMG_WIDTH    = 640;
    localparam int DEF_IMG_HEIGHT   = 480;
    localparam int DEF_BLOCK_WIDTH  = 3;
    localparam int DEF_BLOCK_HEIGHT = 3;

endpackage

// File: rtl/kernel_window_ctrl_raster_counter.sv
// raster_counter: x/y raster position with enable, wrapping at end of row and frame.
module raster_counter
    import hog_pkg::*;
#(
    parameter int WIDTH  = DEF_IMG_WIDTH,
    parameter int HEIGHT = DEF_IMG_HEIGHT,
    parameter int X_W    = $clog2(WIDTH),
    parameter int Y_W    = $clog2(HEIGHT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           end_of_row,
    output logic           end_of_frame
);

    localparam logic [X_W-1:0] LAST_X = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(HEIGHT - 1);

    assign end_of_row   = (x == LAST_X);
    assign end_of_frame = end_of_row && (y == LAST_Y);

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (end_of_row) begin
                x <= '0;
                y <= (y == LAST_Y) ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/kernel_window_ctrl.sv
// Sliding-window sequencing controller for the HOG kernel shift register.
// Optional window coordinates are enabled with KERNEL_WIN_COORD_EN.
module kernel_window_ctrl
    import hog_pkg::*;
#(
    parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
    parameter int BLOCK_WIDTH  = DEF_BLOCK_WIDTH,
    parameter int BLOCK_HEIGHT = DEF_BLOCK_HEIGHT,
    parameter int X_W          = $clog2(IMG_WIDTH),
    parameter int Y_W          = $clog2(IMG_HEIGHT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           kern_shift,
    output logic           win_valid,
    input  logic           win_ready,
    output logic           win_last,
    output logic           frame_done,
    output logic [X_W-1:0] win_x,
    output logic [Y_W-1:0] win_y
);

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           end_of_row;
    logic           end_of_frame;
    logic           acc;
    logic           x_ok;
    logic           y_ok;
    logic           fill_x_ok;
    logic           qual;
    win_state_t     state;

    assign in_ready   = !win_valid || win_ready;
    assign acc        = in_valid && in_ready;
    assign kern_shift = acc;

    raster_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_raster (
        .clk          (clk),
        .rst          (rst),
        .en           (acc),
        .x            (x),
        .y            (y),
        .end_of_row   (end_of_row),
        .end_of_frame (end_of_frame)
    );

    // Size-1 kernels always qualify; splitting here avoids an always-true unsigned compare.
    if (BLOCK_WIDTH == 1) begin : g_x_unit
        assign x_ok      = 1'b1;
        assign fill_x_ok = 1'b1;
    end else begin : g_x_block
        localparam logic [X_W-1:0] BW_M1 = X_W'(BLOCK_WIDTH - 1);
        localparam logic [X_W-1:0] BW_M2 = X_W'(BLOCK_WIDTH - 2);
        assign x_ok      = (x >= BW_M1);
        assign fill_x_ok = (x == BW_M2);
    end

    if (BLOCK_HEIGHT == 1) begin : g_y_unit
        assign y_ok = 1'b1;
    end else begin : g_y_block
        localparam logic [Y_W-1:0] BH_M1 = Y_W'(BLOCK_HEIGHT - 1);
        assign y_ok = (y >= BH_M1);
    end

    assign qual = acc && x_ok && y_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (acc) begin
            case (state)
                S_IDLE:
                    state <= (BLOCK_WIDTH == 1 && BLOCK_HEIGHT == 1) ? S_STREAM : S_FILL;
                S_FILL:
                    if (fill_x_ok && y_ok) state <= S_STREAM;
                S_STREAM:
                    if (end_of_row) state <= end_of_frame ? S_IDLE : S_FILL;
                default:
                    state <= S_IDLE;
            endcase
        end
    end

    // A qualified beat reloads the window register even while the old window drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid  <= 1'b0;
            win_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= win_valid && win_ready && win_last;
            if (qual) begin
                win_valid <= 1'b1;
                win_last  <= end_of_frame;
            end else if (win_ready) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

`ifdef KERNEL_WIN_COORD_EN
    if (1) begin : g_coord
        localparam logic [X_W-1:0] CX = X_W'(BLOCK_WIDTH - 1);
        localparam logic [Y_W-1:0] CY = Y_W'(BLOCK_HEIGHT - 1);

        always_ff @(posedge clk) begin
            if (rst) begin
                win_x <= '0;
                win_y <= '0;
            end else if (qual) begin
                win_x <= x - CX;
                win_y <= y - CY;
            end
        end
    end
`else
    assign win_x = '0;
    assign win_y = '0;
`endif

endmodule

// File: tb/tb_kernel_window_ctrl.sv
// Directed bench for kernel_window_ctrl on an 8x4 image with 3x3 and 1x1 kernels.
module tb_kernel_window_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       win_ready;
    logic       in_ready;
    logic       kern_shift;
    logic       win_valid;
    logic       win_last;
    logic       frame_done;
    logic [2:0] win_x;
    logic [1:0] win_y;

    logic       u1_in_valid;
    logic       u1_win_ready;
    logic       u1_in_ready;
    logic       u1_kern_shift;
    logic       u1_win_valid;
    logic       u1_win_last;
    logic       u1_frame_done;
    logic [2:0] u1_win_x;
    logic [1:0] u1_win_y;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kernel_window_ctrl #(
        .IMG_WIDTH    (8),
        .IMG_HEIGHT   (4),
        .BLOCK_WIDTH  (3),
        .BLOCK_HEIGHT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .kern_shift (kern_shift),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_last   (win_last),
        .frame_done (frame_done),
        .win_x      (win_x),
        .win_y      (win_y)
    );

    kernel_window_ctrl #(
        .IMG_WIDTH    (8),
        .IMG_HEIGHT   (4),
        .BLOCK_WIDTH  (1),
        .BLOCK_HEIGHT (1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (u1_in_valid),
        .in_ready   (u1_in_ready),
        .kern_shift (u1_kern_shift),
        .win_valid  (u1_win_valid),
        .win_ready  (u1_win_ready),
        .win_last   (u1_win_last),
        .frame_done (u1_frame_done),
        .win_x      (u1_win_x),
        .win_y      (u1_win_y)
    );

    task automatic do_reset;
        rst          = 1'b1;
        in_valid     = 1'b0;
        win_ready    = 1'b1;
        u1_in_valid  = 1'b0;
        u1_win_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        in_valid     = 1'b0;
        win_ready    = 1'b1;
        u1_in_valid  = 1'b0;
        u1_win_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (win_valid !== 1'b0)  begin failures++; $display("[TB] FAIL reset_win_valid: got %b expected 0", win_valid); end
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (win_last !== 1'b0)   begin failures++; $display("[TB] FAIL reset_win_last: got %b expected 0", win_last); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (win_x !== 3'd0 || win_y !== 2'd0) begin failures++; $display("[TB] FAIL reset_coord: got (%0d,%0d) expected (0,0)", win_x, win_y); end
        checks++; if (u1_win_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_u1_win_valid: got %b expected 0", u1_win_valid); end
        rst = 1'b0;
    endtask

    // Continuous stream of one full frame; expectations come from the raster position of each beat.
    task automatic test_stream;
        int         nwin;
        logic       ev;
        logic       el;
        logic [2:0] ex;
        logic [1:0] ey;
        nwin      = 0;
        in_valid  = 1'b1;
        win_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            ev = ((k % 8) >= 2) && ((k / 8) >= 2);
            el = (k == 31);
            ex = 3'((k % 8) - 2);
            ey = 2'((k / 8) - 2);
            checks++; if (win_valid !== ev) begin failures++; $display("[TB] FAIL stream_win_valid beat %0d: got %b expected %b", k, win_valid, ev); end
            checks++; if (win_last !== el) begin failures++; $display("[TB] FAIL stream_win_last beat %0d: got %b expected %b", k, win_last, el); end
            checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL stream_frame_done beat %0d: got %b expected 0", k, frame_done); end
            checks++; if (kern_shift !== 1'b1) begin failures++; $display("[TB] FAIL stream_kern_shift beat %0d: got %b expected 1", k, kern_shift); end
`ifdef KERNEL_WIN_COORD_EN
            if (ev) begin
                checks++; if (win_x !== ex || win_y !== ey) begin failures++; $display("[TB] FAIL stream_coord beat %0d: got (%0d,%0d) expected (%0d,%0d)", k, win_x, win_y, ex, ey); end
            end
`else
            checks++; if (win_x !== 3'd0 || win_y !== 2'd0) begin failures++; $display("[TB] FAIL stream_coord_tied beat %0d: got (%0d,%0d) expected (0,0) ex=%0d ey=%0d", k, win_x, win_y, ex, ey); end
`endif
            if (win_valid === 1'b1) nwin++;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (frame_done !== 1'b1) begin failures++; $display("[TB] FAIL stream_frame_done_pulse: got %b expected 1", frame_done); end
        checks++; if (win_valid !== 1'b0)  begin failures++; $display("[TB] FAIL stream_drained: got %b expected 0", win_valid); end
        @(posedge clk);
        #1;
        checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL stream_frame_done_single: got %b expected 0", frame_done); end
        checks++; if (nwin != 12) begin failures++; $display("[TB] FAIL stream_window_count: got %0d expected 12", nwin); end
    endtask

    task automatic test_reset_mid_frame;
        do_reset();
        in_valid  = 1'b1;
        win_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (win_valid !== 1'b1) begin failures++; $display("[TB] FAIL midreset_pre_valid: got %b expected 1", win_valid); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (win_valid !== 1'b0)  begin failures++; $display("[TB] FAIL midreset_win_valid: got %b expected 0", win_valid); end
        checks++; if (win_last !== 1'b0)   begin failures++; $display("[TB] FAIL midreset_win_last: got %b expected 0", win_last); end
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("[TB] FAIL midreset_in_ready: got %b expected 1", in_ready); end
        checks++; if (win_x !== 3'd0 || win_y !== 2'd0) begin failures++; $display("[TB] FAIL midreset_coord: got (%0d,%0d) expected (0,0)", win_x, win_y); end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    // Stall the consumer for 5 cycles just after window (2,0) appears, then resume.
    task automatic test_backpressure;
        int         nwin;
        logic       ev;
        logic [2:0] ex;
        logic [1:0] ey;
        do_reset();
        nwin      = 0;
        in_valid  = 1'b1;
        win_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k == 21) begin
                win_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk);
                    #1;
                    checks++; if (in_ready !== 1'b0)   begin failures++; $display("[TB] FAIL bp_in_ready cycle %0d: got %b expected 0", s, in_ready); end
                    checks++; if (kern_shift !== 1'b0) begin failures++; $display("[TB] FAIL bp_kern_shift cycle %0d: got %b expected 0", s, kern_shift); end
                    checks++; if (win_valid !== 1'b1)  begin failures++; $display("[TB] FAIL bp_win_valid cycle %0d: got %b expected 1", s, win_valid); end
`ifdef KERNEL_WIN_COORD_EN
                    checks++; if (win_x !== 3'd2 || win_y !== 2'd0) begin failures++; $display("[TB] FAIL bp_coord_hold cycle %0d: got (%0d,%0d) expected (2,0)", s, win_x, win_y); end
`endif
                end
                win_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            ev = ((k % 8) >= 2) && ((k / 8) >= 2);
            ex = 3'((k % 8) - 2);
            ey = 2'((k / 8) - 2);
            checks++; if (win_valid !== ev) begin failures++; $display("[TB] FAIL bp_win_valid beat %0d: got %b expected %b", k, win_valid, ev); end
`ifdef KERNEL_WIN_COORD_EN
            if (ev) begin
                checks++; if (win_x !== ex || win_y !== ey) begin failures++; $display("[TB] FAIL bp_coord beat %0d: got (%0d,%0d) expected (%0d,%0d)", k, win_x, win_y, ex, ey); end
            end
`endif
            if (win_valid === 1'b1) nwin++;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (frame_done !== 1'b1) begin failures++; $display("[TB] FAIL bp_frame_done: got %b expected 1", frame_done); end
        checks++; if (nwin != 12) begin failures++; $display("[TB] FAIL bp_window_count: got %0d expected 12 (ex=%0d ey=%0d)", nwin, ex, ey); end
    endtask

    task automatic test_unit_block;
        int         nwin;
        logic [2:0] ex;
        logic [1:0] ey;
        do_reset();
        nwin         = 0;
        u1_in_valid  = 1'b1;
        u1_win_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            #1;
            ex = 3'(k % 8);
            ey = 2'(k / 8);
            checks++; if (u1_win_valid !== 1'b1) begin failures++; $display("[TB] FAIL unit_win_valid beat %0d: got %b expected 1", k, u1_win_valid); end
            checks++; if (u1_win_last !== (k == 31)) begin failures++; $display("[TB] FAIL unit_win_last beat %0d: got %b expected %b", k, u1_win_last, (k == 31)); end
`ifdef KERNEL_WIN_COORD_EN
            checks++; if (u1_win_x !== ex || u1_win_y !== ey) begin failures++; $display("[TB] FAIL unit_coord beat %0d: got (%0d,%0d) expected (%0d,%0d)", k, u1_win_x, u1_win_y, ex, ey); end
`endif
            if (u1_win_valid === 1'b1) nwin++;
        end
        u1_in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (u1_frame_done !== 1'b1) begin failures++; $display("[TB] FAIL unit_frame_done: got %b expected 1", u1_frame_done); end
        checks++; if (u1_win_valid !== 1'b0)  begin failures++; $display("[TB] FAIL unit_drained: got %b expected 0", u1_win_valid); end
        checks++; if (nwin != 32) begin failures++; $display("[TB] FAIL unit_window_count: got %0d expected 32 (last %0d,%0d)", nwin, ex, ey); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reset_mid_frame();
        test_stream();
        test_backpressure();
        test_unit_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
